uart_rx_deserializer: RTL and testbench

//  8-bit UART receiver fed by the 3-FF input synchronizer on the RX pin; rx is already synchronous to clk.
//  - Detects the start bit, samples each bit at mid-bit, checks the stop bit.
//  - Delivers each byte through a one-entry valid/ready buffer to the SoC UART peripheral.
//  - Flags framing errors and overruns.

---
 rtl/uart_rx_deserializer.sv | 149 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// 8-bit UART receiver with mid-bit sampling, stop-bit check and a one-entry valid/ready output buffer.
// Define UART_RX_PARITY_EN to receive a parity bit (PARITY_ODD selects odd/even); default frame is 8N1.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  // Parity configuration has no effect in 8N1 builds.
  assign parity_err_o = PARITY_ODD[0] & 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= WAIT_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      case (state)
        // A line held low after a framing error must return high before a new start is accepted.
        WAIT_IDLE: begin
          if (rx) state <= IDLE;
        end
        IDLE: begin
          if (!rx) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= rx ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rx, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_bad <= (rx != (^shreg ^ PARITY_ODD[0]));
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!rx) begin
              frame_err_o <= 1'b1;
              state       <= WAIT_IDLE;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad) begin
              parity_err_o <= 1'b1;
              state        <= IDLE;
            end
`endif
            else begin
              state <= IDLE;
              // A same-cycle consume frees the buffer for the new byte.
              if (!valid_o || ready_i) begin
                data_o  <= shreg;
                valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit; honours UART_RX_PARITY_EN.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 169;
`else
  localparam int LAT = 153;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       frame_err_o;
  logic       overrun_o;
  logic       parity_err_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int vrise_cnt = 0;
  int last_rise_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  logic valid_q = 1'b0;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk(clk),
    .resetn(resetn),
    .rx(rx),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  // Cycle-accurate observer: counts high cycles of each pulse and records valid_o rising edges.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (valid_o && !valid_q) begin
      vrise_cnt     = vrise_cnt + 1;
      last_rise_cyc = cyc;
    end
    valid_q = valid_o;
    if (frame_err_o)  fe_cnt = fe_cnt + 1;
    if (overrun_o)    ov_cnt = ov_cnt + 1;
    if (parity_err_o) pe_cnt = pe_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_bit);
  endtask

  task automatic consume();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out: valid=%b data=%h expected valid=0 data=00", valid_o, data_o);
    end
    vectors++;
    if (frame_err_o !== 1'b0 || overrun_o !== 1'b0 || parity_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: fe=%b ov=%b pe=%b expected all 0", frame_err_o, overrun_o, parity_err_o);
    end
    resetn = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int s;
    int r0 = vrise_cnt;
    send_frame(8'hA5, 1'b1, s);
    vectors++;
    if (vrise_cnt !== r0 + 1 || last_rise_cyc - s !== LAT) begin
      miscompares++;
      $display("FAIL basic_latency: rises=%0d lat=%0d expected rises=%0d lat=%0d",
               vrise_cnt - r0, last_rise_cyc - s, 1, LAT);
    end
    vectors++;
    if (data_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_data: got %h expected a5", data_o);
    end
    idle(10);
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_hold: valid=%b data=%h expected valid=1 data=a5", valid_o, data_o);
    end
    consume();
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_consume: valid=%b expected 0", valid_o);
    end
  endtask

  task automatic test_false_start();
    int s;
    int r0 = vrise_cnt;
    int f0 = fe_cnt;
    int o0 = ov_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(20);
    vectors++;
    if (vrise_cnt !== r0 || fe_cnt !== f0 || ov_cnt !== o0) begin
      miscompares++;
      $display("FAIL false_start: rises=%0d fe=%0d ov=%0d expected 0 0 0",
               vrise_cnt - r0, fe_cnt - f0, ov_cnt - o0);
    end
    send_frame(8'hC3, 1'b1, s);
    vectors++;
    if (data_o !== 8'hC3 || last_rise_cyc - s !== LAT) begin
      miscompares++;
      $display("FAIL false_start_next: data=%h lat=%0d expected c3 %0d", data_o, last_rise_cyc - s, LAT);
    end
    consume();
  endtask

  task automatic test_frame_err();
    int s;
    int r0 = vrise_cnt;
    int f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, s);
    vectors++;
    if (fe_cnt !== f0 + 1 || vrise_cnt !== r0) begin
      miscompares++;
      $display("FAIL frame_err: fe_cycles=%0d rises=%0d expected 1 0", fe_cnt - f0, vrise_cnt - r0);
    end
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(4);
    vectors++;
    if (fe_cnt !== f0 + 1 || vrise_cnt !== r0) begin
      miscompares++;
      $display("FAIL stuck_low: fe_cycles=%0d rises=%0d expected 1 0", fe_cnt - f0, vrise_cnt - r0);
    end
    send_frame(8'h5A, 1'b1, s);
    vectors++;
    if (data_o !== 8'h5A || vrise_cnt !== r0 + 1 || last_rise_cyc - s !== LAT) begin
      miscompares++;
      $display("FAIL recover: data=%h rises=%0d lat=%0d expected 5a 1 %0d",
               data_o, vrise_cnt - r0, last_rise_cyc - s, LAT);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int s1;
    int s2;
    int o0 = ov_cnt;
    int r0 = vrise_cnt;
    send_frame(8'h11, 1'b1, s1);
    send_frame(8'h22, 1'b1, s2);
    vectors++;
    if (ov_cnt !== o0 + 1 || vrise_cnt !== r0 + 1) begin
      miscompares++;
      $display("FAIL overrun: ov_cycles=%0d rises=%0d expected 1 1", ov_cnt - o0, vrise_cnt - r0);
    end
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 8'h11) begin
      miscompares++;
      $display("FAIL overrun_keep: valid=%b data=%h expected 1 11", valid_o, data_o);
    end
    consume();
    send_frame(8'h11, 1'b1, s1);
    fork
      send_frame(8'h22, 1'b1, s2);
      begin
        repeat (LAT - 1) @(negedge clk);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
      end
    join
    vectors++;
    if (valid_o !== 1'b1 || data_o !== 8'h22 || ov_cnt !== o0 + 1) begin
      miscompares++;
      $display("FAIL same_cycle_consume: valid=%b data=%h ov_cycles=%0d expected 1 22 1",
               valid_o, data_o, ov_cnt - o0);
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    int r0 = vrise_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    resetn = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    vectors++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      miscompares++;
      $display("FAIL midframe_reset: valid=%b data=%h expected 0 00", valid_o, data_o);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle(CPB * 8);
    vectors++;
    if (vrise_cnt !== r0) begin
      miscompares++;
      $display("FAIL midframe_drop: rises=%0d expected 0", vrise_cnt - r0);
    end
    send_frame(8'hFF, 1'b1, s);
    vectors++;
    if (data_o !== 8'hFF || vrise_cnt !== r0 + 1 || last_rise_cyc - s !== LAT) begin
      miscompares++;
      $display("FAIL after_reset: data=%h rises=%0d lat=%0d expected ff 1 %0d",
               data_o, vrise_cnt - r0, last_rise_cyc - s, LAT);
    end
    consume();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int s;
    int r0 = vrise_cnt;
    int p0 = pe_cnt;
    int f0 = fe_cnt;
    logic [7:0] d = 8'h07;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    vectors++;
    if (pe_cnt !== p0 + 1 || vrise_cnt !== r0 || fe_cnt !== f0) begin
      miscompares++;
      $display("FAIL parity_bad: pe_cycles=%0d rises=%0d fe=%0d expected 1 0 0",
               pe_cnt - p0, vrise_cnt - r0, fe_cnt - f0);
    end
    idle(2);
    send_frame(8'h07, 1'b1, s);
    vectors++;
    if (data_o !== 8'h07 || pe_cnt !== p0 + 1 || last_rise_cyc - s !== LAT) begin
      miscompares++;
      $display("FAIL parity_good: data=%h pe_cycles=%0d lat=%0d expected 07 1 %0d",
               data_o, pe_cnt - p0, last_rise_cyc - s, LAT);
    end
    consume();
  endtask
`else
  task automatic test_parity();
    vectors++;
    if (pe_cnt !== 0) begin
      miscompares++;
      $display("FAIL parity_tied: pe_cycles=%0d expected 0", pe_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
